// File: rtl/spi_cmd_loader.sv
// SPI mode-0 slave and byte-command decoder feeding the burst_dds SRAM write stream.
// Pins are oversampled in the HS_CLK domain; outputs are a valid/ready write port, burst length and arm pulse.
module spi_cmd_loader #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              HS_CLK,
    input  logic              RST,
    input  logic              SCK,
    input  logic              MOSI,
    input  logic              SPI_CE,
    output logic              MISO,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              WR_VALID,
    input  logic              WR_READY,
    output logic [ADDR_W-1:0] BURST_LEN,
    output logic              ARM,
    output logic              OVERRUN,
    input  logic              BUSY
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, LEN, IGNORE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ce_sync;
    logic                   sck_prev, ce_prev;
    logic                   sck_s, mosi_s, ce_s;
    logic                   sck_rise, sck_fall, ce_fall;

    logic [2:0]             bit_cnt;
    logic [DATA_W-1:0]      rx_sh, rx_byte;
    logic [DATA_W-1:0]      status_sh;
    logic [1:0]             field_cnt;
    logic [3*DATA_W-1:0]    field, field_next;
    logic [ADDR_W-1:0]      field_val;
    logic                   addr_pend;
    logic [ADDR_W-1:0]      addr_pend_val;

    logic active, byte_done, fire;
    logic load_addr, load_len, arm_d, set_ovr, clr_ovr, accept;

    // Synchronizers and edge history are free-running (not reset) so that releasing
    // RST with SPI_CE already low never manufactures a false chip-enable edge.
    always_ff @(posedge HS_CLK) begin
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        ce_sync   <= {ce_sync[SYNC_STAGES-2:0], SPI_CE};
        sck_prev  <= sck_sync[SYNC_STAGES-1];
        ce_prev   <= ce_sync[SYNC_STAGES-1];
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign ce_s     = ce_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign ce_fall  = ~ce_s & ce_prev;

    assign active     = ~ce_s && (state_q != IDLE);
    assign byte_done  = active && sck_rise && (bit_cnt == 3'd7);
    assign rx_byte    = {rx_sh[DATA_W-2:0], mosi_s};
    assign field_next = {field[2*DATA_W-1:0], rx_byte};
    assign field_val  = field_next[ADDR_W-1:0];
    assign fire       = WR_VALID && WR_READY;

    always_ff @(posedge HS_CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_addr = 1'b0;
        load_len  = 1'b0;
        arm_d     = 1'b0;
        set_ovr   = 1'b0;
        clr_ovr   = 1'b0;
        accept    = 1'b0;
        if (ce_fall) begin
            state_d = CMD;
        end else if (ce_s) begin
            state_d = IDLE;
        end else if (byte_done) begin
            case (state_q)
                CMD: begin
                    case (rx_byte)
                        8'h01:   state_d = ADDR;
                        8'h02:   state_d = DATA;
                        8'h03:   state_d = LEN;
                        8'h04: begin
                            state_d = IGNORE;
                            if (BUSY) set_ovr = 1'b1;
                            else      arm_d   = 1'b1;
                        end
                        8'h05: begin
                            state_d = IGNORE;
                            clr_ovr = 1'b1;
                        end
                        default: state_d = IGNORE;
                    endcase
                end
                ADDR: begin
                    if (field_cnt == 2'd2) begin
                        load_addr = 1'b1;
                        state_d   = IGNORE;
                    end
                end
                LEN: begin
                    if (field_cnt == 2'd2) begin
                        load_len = 1'b1;
                        state_d  = IGNORE;
                    end
                end
                DATA: begin
                    if (!BUSY && (!WR_VALID || WR_READY)) accept  = 1'b1;
                    else                                   set_ovr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge HS_CLK) begin
        if (RST) begin
            MISO          <= 1'b0;
            WR_ADDR       <= '0;
            WR_DATA       <= '0;
            WR_VALID      <= 1'b0;
            BURST_LEN     <= '0;
            ARM           <= 1'b0;
            OVERRUN       <= 1'b0;
            bit_cnt       <= '0;
            rx_sh         <= '0;
            status_sh     <= '0;
            field_cnt     <= '0;
            field         <= '0;
            addr_pend     <= 1'b0;
            addr_pend_val <= '0;
        end else begin
            if (ce_fall) begin
                bit_cnt   <= '0;
                MISO      <= BUSY;
                status_sh <= {OVERRUN, {(DATA_W-1){1'b0}}};
            end else if (ce_s) begin
                MISO      <= 1'b0;
                status_sh <= '0;
            end else if (active) begin
                if (sck_rise) begin
                    rx_sh   <= rx_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (sck_fall) begin
                    MISO      <= status_sh[DATA_W-1];
                    status_sh <= {status_sh[DATA_W-2:0], 1'b0};
                end
            end

            if (byte_done) begin
                if (state_q == ADDR || state_q == LEN) begin
                    field     <= field_next;
                    field_cnt <= field_cnt + 2'd1;
                end else begin
                    field_cnt <= '0;
                end
            end

            ARM <= arm_d;
            if (clr_ovr)      OVERRUN <= 1'b0;
            else if (set_ovr) OVERRUN <= 1'b1;

            if (load_len) BURST_LEN <= field_val;

            if (accept) begin
                WR_DATA  <= rx_byte;
                WR_VALID <= 1'b1;
            end else if (fire) begin
                WR_VALID <= 1'b0;
            end

            // An address load during a pending write waits for the handshake, then replaces the increment.
            if (fire) begin
                if (load_addr)      WR_ADDR <= field_val;
                else if (addr_pend) WR_ADDR <= addr_pend_val;
                else                WR_ADDR <= WR_ADDR + ADDR_W'(1);
                addr_pend <= 1'b0;
            end else if (load_addr) begin
                if (WR_VALID) begin
                    addr_pend     <= 1'b1;
                    addr_pend_val <= field_val;
                end else begin
                    WR_ADDR <= field_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_loader.sv
// Directed bench for spi_cmd_loader: bit-banged SPI frames with hand-computed expectations.
`timescale 1ns/1ps
module tb_spi_cmd_loader;

    logic        HS_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SCK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SPI_CE = 1'b1;
    logic        MISO;
    logic [16:0] WR_ADDR;
    logic [7:0]  WR_DATA;
    logic        WR_VALID;
    logic        WR_READY = 1'b1;
    logic [16:0] BURST_LEN;
    logic        ARM;
    logic        OVERRUN;
    logic        BUSY = 1'b0;

    int asserts = 0;
    int failures = 0;
    int arm_cnt = 0;
    logic [16:0] wa_q[$];
    logic [7:0]  wd_q[$];

    spi_cmd_loader #(.ADDR_W(17), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .HS_CLK(HS_CLK), .RST(RST), .SCK(SCK), .MOSI(MOSI), .SPI_CE(SPI_CE),
        .MISO(MISO), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_VALID(WR_VALID),
        .WR_READY(WR_READY), .BURST_LEN(BURST_LEN), .ARM(ARM), .OVERRUN(OVERRUN),
        .BUSY(BUSY)
    );

    always #5 HS_CLK = ~HS_CLK;

    // Inputs only change 1 ns after a rising edge, so the falling edge sees what the next rise will.
    always @(negedge HS_CLK) begin
        if (!RST && WR_VALID && WR_READY) begin
            wa_q.push_back(WR_ADDR);
            wd_q.push_back(WR_DATA);
        end
        if (!RST && ARM) arm_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge HS_CLK);
        #1;
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = b[7-i];
            tick(8);
            rx = {rx[6:0], MISO};
            SCK = 1'b1;
            tick(8);
            SCK = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input int n, output logic [7:0] status);
        logic [7:0] d;
        SPI_CE = 1'b0;
        tick(10);
        spi_bits(b0, 8, status);
        if (n > 1) spi_bits(b1, 8, d);
        if (n > 2) spi_bits(b2, 8, d);
        if (n > 3) spi_bits(b3, 8, d);
        tick(10);
        SPI_CE = 1'b1;
        tick(10);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        tick(6);
        asserts++;
        if ({MISO, WR_ADDR, WR_DATA, WR_VALID, BURST_LEN, ARM, OVERRUN} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got MISO=%b ADDR=%h DATA=%h VALID=%b LEN=%h ARM=%b OVR=%b, want all 0",
                     MISO, WR_ADDR, WR_DATA, WR_VALID, BURST_LEN, ARM, OVERRUN);
        end
        RST = 1'b0;
        tick(4);
    endtask

    task automatic test_write_stream;
        logic [7:0] st;
        wa_q.delete(); wd_q.delete();
        frame(8'h01, 8'h00, 8'h12, 8'h34, 4, st);
        frame(8'h02, 8'hAA, 8'hBB, 8'h00, 3, st);
        asserts++;
        if (wa_q.size() != 2) begin
            failures++;
            $display("FAIL stream_count: got %0d writes, want 2", wa_q.size());
        end else begin
            asserts++;
            if (wa_q[0] !== 17'h01234 || wd_q[0] !== 8'hAA) begin
                failures++;
                $display("FAIL stream_w0: got (%h,%h), want (01234,aa)", wa_q[0], wd_q[0]);
            end
            asserts++;
            if (wa_q[1] !== 17'h01235 || wd_q[1] !== 8'hBB) begin
                failures++;
                $display("FAIL stream_w1: got (%h,%h), want (01235,bb)", wa_q[1], wd_q[1]);
            end
        end
        asserts++;
        if (WR_ADDR !== 17'h01236 || OVERRUN !== 1'b0 || WR_VALID !== 1'b0) begin
            failures++;
            $display("FAIL stream_end: got ADDR=%h OVR=%b VALID=%b, want 01236 0 0", WR_ADDR, OVERRUN, WR_VALID);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] st;
        wa_q.delete(); wd_q.delete();
        frame(8'h01, 8'h01, 8'hFF, 8'hFF, 4, st);
        asserts++;
        if (WR_ADDR !== 17'h1FFFF) begin
            failures++;
            $display("FAIL wrap_load: got ADDR=%h, want 1ffff", WR_ADDR);
        end
        frame(8'h02, 8'h11, 8'h22, 8'h00, 3, st);
        asserts++;
        if (wa_q.size() != 2 || wa_q[0] !== 17'h1FFFF || wd_q[0] !== 8'h11 ||
            wa_q[1] !== 17'h00000 || wd_q[1] !== 8'h22) begin
            failures++;
            $display("FAIL wrap_writes: got %0d writes first=(%h,%h), want (1ffff,11),(00000,22)",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 17'h0, (wd_q.size() > 0) ? wd_q[0] : 8'h0);
        end
        asserts++;
        if (WR_ADDR !== 17'h00001) begin
            failures++;
            $display("FAIL wrap_end: got ADDR=%h, want 00001", WR_ADDR);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] st;
        wa_q.delete(); wd_q.delete();
        WR_READY = 1'b0;
        frame(8'h02, 8'h01, 8'h02, 8'h03, 4, st);
        asserts++;
        if (WR_VALID !== 1'b1 || WR_DATA !== 8'h01 || WR_ADDR !== 17'h00001 || wa_q.size() != 0) begin
            failures++;
            $display("FAIL bp_hold: got VALID=%b DATA=%h ADDR=%h writes=%0d, want 1 01 00001 0",
                     WR_VALID, WR_DATA, WR_ADDR, wa_q.size());
        end
        asserts++;
        if (OVERRUN !== 1'b1) begin
            failures++;
            $display("FAIL bp_overrun: got OVR=%b, want 1", OVERRUN);
        end
        frame(8'h05, 8'h00, 8'h00, 8'h00, 1, st);
        asserts++;
        if (st !== 8'h40) begin
            failures++;
            $display("FAIL bp_status: got MISO byte %h, want 40", st);
        end
        asserts++;
        if (OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL bp_clear: got OVR=%b, want 0", OVERRUN);
        end
        WR_READY = 1'b1;
        tick(4);
        asserts++;
        if (wa_q.size() != 1 || wa_q[0] !== 17'h00001 || wd_q[0] !== 8'h01 ||
            WR_ADDR !== 17'h00002 || WR_VALID !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got writes=%0d ADDR=%h VALID=%b, want 1 write (00001,01), ADDR 00002, VALID 0",
                     wa_q.size(), WR_ADDR, WR_VALID);
        end
    endtask

    task automatic test_len_arm;
        logic [7:0] st;
        int arm_before;
        frame(8'h03, 8'h00, 8'h04, 8'h00, 4, st);
        asserts++;
        if (BURST_LEN !== 17'h00400) begin
            failures++;
            $display("FAIL len_load: got LEN=%h, want 00400", BURST_LEN);
        end
        arm_before = arm_cnt;
        frame(8'h04, 8'h00, 8'h00, 8'h00, 1, st);
        asserts++;
        if (arm_cnt - arm_before != 1 || OVERRUN !== 1'b0) begin
            failures++;
            $display("FAIL arm_idle: got %0d ARM cycles OVR=%b, want 1 cycle OVR=0", arm_cnt - arm_before, OVERRUN);
        end
        BUSY = 1'b1;
        arm_before = arm_cnt;
        frame(8'h04, 8'h00, 8'h00, 8'h00, 1, st);
        asserts++;
        if (arm_cnt != arm_before || OVERRUN !== 1'b1) begin
            failures++;
            $display("FAIL arm_busy: got %0d ARM cycles OVR=%b, want 0 cycles OVR=1", arm_cnt - arm_before, OVERRUN);
        end
        asserts++;
        if (MISO !== 1'b0) begin
            failures++;
            $display("FAIL miso_idle: got MISO=%b with CE high, want 0", MISO);
        end
    endtask

    task automatic test_abort_ignore;
        logic [7:0] st;
        int arm_before;
        wa_q.delete(); wd_q.delete();
        frame(8'h01, 8'h00, 8'h12, 8'h00, 3, st);
        asserts++;
        if (WR_ADDR !== 17'h00002) begin
            failures++;
            $display("FAIL abort_addr: got ADDR=%h, want 00002", WR_ADDR);
        end
        arm_before = arm_cnt;
        frame(8'h7E, 8'h11, 8'h22, 8'h33, 4, st);
        asserts++;
        if (st !== 8'hC0) begin
            failures++;
            $display("FAIL busy_status: got MISO byte %h, want c0", st);
        end
        asserts++;
        if (WR_ADDR !== 17'h00002 || BURST_LEN !== 17'h00400 || OVERRUN !== 1'b1 ||
            WR_VALID !== 1'b0 || arm_cnt != arm_before || wa_q.size() != 0) begin
            failures++;
            $display("FAIL ignore_opcode: got ADDR=%h LEN=%h OVR=%b VALID=%b arms=%0d writes=%0d, want 00002 00400 1 0 0 0",
                     WR_ADDR, BURST_LEN, OVERRUN, WR_VALID, arm_cnt - arm_before, wa_q.size());
        end
        BUSY = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic [7:0] st;
        wa_q.delete(); wd_q.delete();
        SPI_CE = 1'b0;
        tick(10);
        spi_bits(8'h02, 8, d);
        spi_bits(8'h55, 4, d);
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        tick(2);
        spi_bits(8'h50, 4, d);
        spi_bits(8'h66, 8, d);
        tick(10);
        asserts++;
        if ({MISO, WR_ADDR, WR_DATA, WR_VALID, BURST_LEN, ARM, OVERRUN} !== '0 || wa_q.size() != 0) begin
            failures++;
            $display("FAIL rst_mid: got MISO=%b ADDR=%h DATA=%h VALID=%b LEN=%h ARM=%b OVR=%b writes=%0d, want all 0",
                     MISO, WR_ADDR, WR_DATA, WR_VALID, BURST_LEN, ARM, OVERRUN, wa_q.size());
        end
        SPI_CE = 1'b1;
        tick(10);
        frame(8'h02, 8'h55, 8'h00, 8'h00, 2, st);
        asserts++;
        if (wa_q.size() != 1 || wa_q[0] !== 17'h00000 || wd_q[0] !== 8'h55 || WR_ADDR !== 17'h00001) begin
            failures++;
            $display("FAIL rst_resume: got writes=%0d ADDR=%h, want 1 write (00000,55) then ADDR 00001",
                     wa_q.size(), WR_ADDR);
        end
    endtask

    initial begin
        test_reset();
        test_write_stream();
        test_wrap();
        test_backpressure();
        test_len_arm();
        test_abort_ignore();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
